// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: integrates synapse activation into a leaky
// membrane potential, fires a one-cycle spike at threshold, then blanks input.
module lif_neuron #(
    parameter int unsigned THRESHOLD      = 128,
    parameter int unsigned LEAK_SHIFT     = 3,
    parameter int unsigned REFRACT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [0:7] activation,
    input  logic       enable,
    output logic       post_spike,
    output logic       refractory,
    output logic [0:7] membrane
);

    localparam int unsigned VW = 8;
    localparam int unsigned SW = VW + 1;
    localparam int unsigned CW = 4;

    typedef enum logic {
        ST_INTEG  = 1'b0,
        ST_REFRAC = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [VW-1:0]   membrane_q, membrane_d;
    logic            spike_q, spike_d;
    logic            refr_q, refr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [VW-1:0]   v_leaked;
    logic [SW-1:0]   v_sum;
    logic [VW-1:0]   v_sat;
    logic            fire;

    // Leak never underflows since v >> LEAK_SHIFT <= v; sum is 9 bits and saturates.
    always_comb begin
        v_leaked = membrane_q - (membrane_q >> LEAK_SHIFT);
        v_sum    = {1'b0, v_leaked} + {1'b0, activation};
        v_sat    = v_sum[VW] ? {VW{1'b1}} : v_sum[VW-1:0];
        fire     = (v_sat >= VW'(THRESHOLD));
    end

    always_comb begin
        state_d    = state_q;
        membrane_d = membrane_q;
        spike_d    = 1'b0;
        refr_d     = refr_q;
        cnt_d      = cnt_q;

        if (enable) begin
            unique case (state_q)
                ST_INTEG: begin
                    if (fire) begin
                        membrane_d = '0;
                        spike_d    = 1'b1;
                        if (REFRACT_CYCLES > 0) begin
                            state_d = ST_REFRAC;
                            refr_d  = 1'b1;
                            cnt_d   = CW'(REFRACT_CYCLES - 1);
                        end
                    end else begin
                        membrane_d = v_sat;
                    end
                end
                ST_REFRAC: begin
                    membrane_d = '0;
                    if (cnt_q == '0) begin
                        state_d = ST_INTEG;
                        refr_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = ST_INTEG;
                    refr_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INTEG;
            membrane_q <= '0;
            spike_q    <= 1'b0;
            refr_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            membrane_q <= membrane_d;
            spike_q    <= spike_d;
            refr_q     <= refr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign post_spike = spike_q;
    assign refractory = refr_q;
    assign membrane   = membrane_q;

endmodule

// File: doc/lif_neuron.md
Name: lif_neuron

Overview:
- Leaky integrate-and-fire neuron: the stage directly downstream of synapse.
- Consumes the synapse's 8-bit activation and accumulates it into a leaky membrane potential.
- Emits a one-cycle post_spike when the potential crosses threshold, then holds off for a refractory period.
- post_spike feeds back to the synapse's post_spike input for STDP.

Parameters:
- THRESHOLD, 128: firing threshold; fire when updated potential >= THRESHOLD (legal range 1..255).
- LEAK_SHIFT, 3: leak per update is v >> LEAK_SHIFT (legal range 1..7).
- REFRACT_CYCLES, 4: cycles of input blanking after a spike (legal range 0..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- activation  input  8 ([0:7], bit 0 = MSB, same ordering as synapse output)  weighted input current from synapse, unsigned.
- enable  input  1  1 = update membrane this cycle; 0 = freeze all state.
- post_spike  output  1  registered one-cycle fire pulse.
- refractory  output  1  registered; high while input is blanked.
- membrane  output  8 ([0:7], bit 0 = MSB)  registered membrane potential, unsigned.

Behaviour:
- Reset (reset=0, asynchronous): membrane=0, post_spike=0, refractory=0, refractory counter=0, state=INTEG. Takes effect immediately, including mid-refractory or on a spike cycle.
- States: INTEG, REFRAC. All outputs are registered; no combinational path from input to output.
- INTEG with enable=1, on each edge:
  - v_next = v - (v >> LEAK_SHIFT) + activation, computed 9 bits wide.
  - Saturate v_next to 255 if bit 8 is set; never wrap.
  - If v_next >= THRESHOLD:
    - membrane<=0, post_spike<=1.
    - If REFRACT_CYCLES>0: state<=REFRAC, refractory<=1, counter<=REFRACT_CYCLES-1.
    - If REFRACT_CYCLES=0: stay in INTEG, refractory stays 0.
  - Else: membrane<=v_next, post_spike<=0.
- REFRAC with enable=1, on each edge:
  - activation is ignored; membrane held at 0; post_spike<=0.
  - If counter==0: state<=INTEG, refractory<=0. Else counter decrements.
  - refractory is therefore high for exactly REFRACT_CYCLES cycles, starting in the same cycle as post_spike.
- enable=0 in any state: no leak, no integration, counter frozen; membrane and refractory hold; post_spike<=0.
  - A pulse already registered still lasts exactly one cycle.
- Latency: activation sampled at edge N is reflected in membrane/post_spike after edge N.
- Leak floor: for v < 2^LEAK_SHIFT the leak term is 0, so the potential holds (no decay to 0).
- Spike spacing: minimum spacing between post_spike pulses is REFRACT_CYCLES+1 cycles.
  - With REFRACT_CYCLES=0 and activation >= THRESHOLD every cycle, post_spike is high every cycle.
- post_spike is never high for two consecutive cycles when REFRACT_CYCLES>0.

Test Plan:
1. Reset: assert reset=0 asynchronously between edges -> membrane=0, post_spike=0, refractory=0 immediately. Release, then enable=1 with activation=0 -> membrane stays 0.
2. Integration to fire (defaults), activation=40, enable=1:
   - membrane 40, 75, 106 after edges 1-3.
   - Edge 4 computes 133 -> post_spike=1 for one cycle, membrane=0, refractory=1 for 4 cycles.
   - First edge after refractory drops -> membrane=40.
3. Saturation: drive membrane to 120, then activation=250 -> 355 saturates to 255 >= 128 -> post_spike=1, membrane=0. A wrapped result (99) would fail this check.
4. Leak and floor: activation=100 for one edge, then 0 -> membrane 100, 88, 77, 68, ... Separately, from membrane=5 with activation=0 -> stays 5.
5. Refractory blanking and freeze:
   - activation=255 throughout refractory -> membrane stays 0, no spike until 4 cycles elapse.
   - enable=0 for 3 cycles mid-refractory -> refractory stretches by 3 cycles, membrane/counter hold.
6. Reset mid-refractory: reset=0 two cycles after a spike -> refractory=0, state INTEG. After release, activation=40 -> membrane=40 on the first edge.
